seven_segment_scan_param: RTL and testbench

SEVEN_SEGMENT_SCAN_PARAM -- requirements
Module: seven_segment_scan_param

---
 rtl/seven_segment_scan_param.sv | 144 ++++++++++++++
 tb/tb_seven_segment_scan_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_param.sv
// Multiplexed hex seven-segment scanner with frame-synchronous load handshake and PWM brightness.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_segment_scan_param #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_BITS   = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] num_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [2:0]              bright,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [7:0]              c_out
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_BITS-1:0]     r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_pending;
  logic                    r_rst_d;
  logic [4*NUM_DIGITS-1:0] r_pend_num;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_disp_num;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [NUM_DIGITS-1:0]   r_an_p1;
  logic [7:0]              r_seg_p1;

  logic                    w_wrap;
  logic                    w_frame;
  logic                    w_accept;
  logic                    w_on;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_blank_mask;
  logic [NUM_DIGITS-1:0]   w_an;
  logic [7:0]              w_seg;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] f_hex7(input logic [3:0] n);
    case (n)
      4'h0: f_hex7 = 7'h40;
      4'h1: f_hex7 = 7'h79;
      4'h2: f_hex7 = 7'h24;
      4'h3: f_hex7 = 7'h30;
      4'h4: f_hex7 = 7'h19;
      4'h5: f_hex7 = 7'h12;
      4'h6: f_hex7 = 7'h02;
      4'h7: f_hex7 = 7'h78;
      4'h8: f_hex7 = 7'h00;
      4'h9: f_hex7 = 7'h10;
      4'hA: f_hex7 = 7'h08;
      4'hB: f_hex7 = 7'h03;
      4'hC: f_hex7 = 7'h46;
      4'hD: f_hex7 = 7'h21;
      4'hE: f_hex7 = 7'h06;
      default: f_hex7 = 7'h0E;
    endcase
  endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // A digit is blanked while no nonzero nibble exists at or above it and its dp is off.
  function automatic logic [NUM_DIGITS-1:0] f_blank(input logic [4*NUM_DIGITS-1:0] v,
                                                    input logic [NUM_DIGITS-1:0]   dp);
    logic seen;
    f_blank = '0;
    seen    = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (v[4*k +: 4] != 4'h0) seen = 1'b1;
      if (!seen && !dp[k]) f_blank[k] = 1'b1;
    end
  endfunction
`else
  function automatic logic [NUM_DIGITS-1:0] f_blank(input logic [4*NUM_DIGITS-1:0] v,
                                                    input logic [NUM_DIGITS-1:0]   dp);
    f_blank = (|v || |dp) ? '0 : '0;
  endfunction
`endif

  assign w_wrap     = &r_presc;
  assign w_frame    = w_wrap && (r_idx == LAST_IDX);
  // Held low for the cycle after reset so a freshly released block never sees a stale handshake.
  assign load_ready = !r_pending && !reset && !r_rst_d;
  assign w_accept   = load_valid && load_ready;
  assign w_on       = (r_presc[DIV_BITS-1 -: 3] <= bright);
  assign w_blank_mask = f_blank(r_disp_num, r_disp_dp);

  always_comb begin
    w_nib   = 4'h0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    w_an    = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib   = r_disp_num[4*k +: 4];
        w_dp    = r_disp_dp[k];
        w_blank = w_blank_mask[k];
      end
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((r_idx == IDX_W'(k)) && w_on && !w_blank) w_an[k] = 1'b0;
    end
    w_seg = w_blank ? 8'hFF : {~w_dp, f_hex7(w_nib)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_rst_d    <= 1'b1;
      r_pend_num <= '0;
      r_pend_dp  <= '0;
      r_disp_num <= '0;
      r_disp_dp  <= '0;
      r_an_p1    <= '1;
      r_seg_p1   <= 8'hFF;
    end else begin
      r_rst_d <= 1'b0;
      r_presc <= r_presc + 1'b1;
      if (w_wrap) r_idx <= w_frame ? '0 : r_idx + 1'b1;
      if (w_frame && r_pending) begin
        r_disp_num <= r_pend_num;
        r_disp_dp  <= r_pend_dp;
        r_pending  <= 1'b0;
      end else if (w_accept) begin
        r_pend_num <= num_in;
        r_pend_dp  <= dp_in;
        r_pending  <= 1'b1;
      end
      // Output stage: reflects the scan state of the previous cycle.
      r_an_p1  <= w_an;
      r_seg_p1 <= w_seg;
    end
  end

  assign an_out = r_an_p1;
  assign c_out  = r_seg_p1;

endmodule

// File: tb/tb_seven_segment_scan_param.sv
// Directed bench for seven_segment_scan_param with NUM_DIGITS=8, DIV_BITS=4.
module tb_seven_segment_scan_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] num_in;
  logic [7:0]  dp_in;
  logic        load_valid;
  logic        load_ready;
  logic [2:0]  bright;
  logic [7:0]  an_out;
  logic [7:0]  c_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lit;

  seven_segment_scan_param #(.NUM_DIGITS(8), .DIV_BITS(4)) dut (
    .clk(clk), .reset(reset), .num_in(num_in), .dp_in(dp_in),
    .load_valid(load_valid), .load_ready(load_ready), .bright(bright),
    .an_out(an_out), .c_out(c_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic count_lit(input int n);
    lit = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (an_out != 8'hFF) lit++;
    end
  endtask

  initial begin
    reset = 1'b1; num_in = '0; dp_in = '0; load_valid = 1'b0; bright = 3'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_an", an_out, 8'hFF);
      chk("rst_c", c_out, 8'hFF);
      chk("rst_rdy", load_ready, 1'b0);
    end
    reset = 1'b0; cyc = 0;
    chk("rel_rdy0", load_ready, 1'b0);
    tick();
    chk("rel_rdy1", load_ready, 1'b1);
    chk("d0_an", an_out, 8'hFE);
    chk("d0_c0", c_out, 8'hC0);

    // Scan
    load_valid = 1'b1; num_in = 32'h0123_4567; dp_in = 8'h02;
    tick();
    load_valid = 1'b0;
    chk("scan_rdy_pend", load_ready, 1'b0);
    run_to(17);
    chk("scan_an_d1", an_out, 8'hFD);
    chk("scan_old_d1", c_out, 8'hC0);
    run_to(128);
    chk("scan_an_d7", an_out, 8'h7F);
    chk("scan_old_d7", c_out, 8'hC0);
    chk("scan_rdy_back", load_ready, 1'b1);
    run_to(129);
    chk("scan_new_an0", an_out, 8'hFE);
    chk("scan_new_c0", c_out, 8'hF8);
    run_to(145);
    chk("scan_new_an1", an_out, 8'hFD);
    chk("scan_new_c1_dp", c_out, 8'h02);
    run_to(257);
    chk("scan_wrap_an", an_out, 8'hFE);
    chk("scan_wrap_c", c_out, 8'hF8);

    // Brightness
    bright = 3'd0;
    count_lit(16);
    chk("bright0", lit, 2);
    bright = 3'd3;
    count_lit(16);
    chk("bright3", lit, 8);
    bright = 3'd7;
    count_lit(16);
    chk("bright7", lit, 16);

    // Handshake
    run_to(310);
    load_valid = 1'b1; num_in = 32'hAAAA_AAAA; dp_in = 8'h00;
    chk("hs_rdy_first", load_ready, 1'b1);
    tick();
    num_in = 32'h5555_5555;
    chk("hs_rdy_held", load_ready, 1'b0);
    run_to(383);
    chk("hs_rdy_wait", load_ready, 1'b0);
    chk("hs_old_c", c_out, 8'hC0);
    run_to(384);
    chk("hs_rdy_rise", load_ready, 1'b1);
    chk("hs_boundary_an", an_out, 8'h7F);
    chk("hs_boundary_c", c_out, 8'hC0);
    tick();
    chk("hs_second_taken", load_ready, 1'b0);
    chk("hs_a_an", an_out, 8'hFE);
    chk("hs_a_c", c_out, 8'h88);
    load_valid = 1'b0;
    run_to(512);
    chk("hs_a_hold", c_out, 8'h88);
    run_to(513);
    chk("hs_5_c", c_out, 8'h92);

    // Reset mid-operation
    load_valid = 1'b1; num_in = 32'hFFFF_FFFF;
    tick();
    load_valid = 1'b0;
    chk("mr_pend", load_ready, 1'b0);
    run_to(520);
    reset = 1'b1;
    tick(); tick();
    chk("mr_an", an_out, 8'hFF);
    chk("mr_c", c_out, 8'hFF);
    chk("mr_rdy", load_ready, 1'b0);
    reset = 1'b0; cyc = 0;
    run_to(1);
    chk("mr_rdy_clear", load_ready, 1'b1);
    run_to(129);
    chk("mr_disp_an", an_out, 8'hFE);
    chk("mr_disp_c", c_out, 8'hC0);

    // Leading zeros
    load_valid = 1'b1; num_in = 32'h0000_00F0; dp_in = 8'h00;
    tick();
    load_valid = 1'b0;
    run_to(257);
    chk("lz_d0_an", an_out, 8'hFE);
    chk("lz_d0_c", c_out, 8'hC0);
    run_to(273);
    chk("lz_d1_an", an_out, 8'hFD);
    chk("lz_d1_c", c_out, 8'h8E);
    run_to(289);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    chk("lz_d2_an", an_out, 8'hFF);
    chk("lz_d2_c", c_out, 8'hFF);
`else
    chk("lz_d2_an", an_out, 8'hFB);
    chk("lz_d2_c", c_out, 8'hC0);
`endif
    run_to(369);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    chk("lz_d7_an", an_out, 8'hFF);
    chk("lz_d7_c", c_out, 8'hFF);
`else
    chk("lz_d7_an", an_out, 8'h7F);
    chk("lz_d7_c", c_out, 8'hC0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
